mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the multi-cycle core's instruction fetch requester (I) and load/store requester (D).
- Sits between the control unit / datapath and the unified memory.
- Grants one transaction at a time, holds the memory request until the memory acknowledges, then returns read data and a one-cycle ack to the owning requester.
- D has fixed priority over I.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT_CYC, 255, max cycles to wait for mem_ack. Used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_  in  1  reset, synchronous, active-low.
- i_req  in  1  fetch request, held until i_ack.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetched word; held until the next I completion.
- i_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  load/store request, held until d_ack.
- d_we  in  1  1 = store.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_size  in  2  access size; same encoding as the core's Size_s.
- d_rdata  out  DW  load data; held until the next D completion.
- d_ack  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  write data.
- mem_size  out  2  access size.
- mem_rdata  in  DW  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- err  out  1  timeout flag pulse, aligned with the ack. Tied 0 without the macro.

Behaviour:
- All outputs are registered. All state changes on the rising clk edge.
- Reset (rst_ low at an edge):
  - state = IDLE.
  - all outputs 0, including i_rdata and d_rdata.
  - Any in-flight transaction is abandoned. A mem_ack arriving after reset is ignored.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - If d_req: latch d_we, d_addr, d_wdata and d_size onto mem_*, set mem_req = 1, go to BUSY_D.
  - Else if i_req: mem_we = 0, mem_addr = i_addr, mem_size = 2'b10, mem_wdata unchanged, mem_req = 1, go to BUSY_I.
  - Else stay in IDLE.
- BUSY_x:
  - mem_* are stable and mem_req stays 1 until mem_ack.
  - On mem_ack: mem_req = 0; capture mem_rdata into x_rdata, except on a store (d_rdata unchanged); x_ack = 1; go to RESP.
- RESP:
  - x_ack high for exactly this one cycle. Requests are ignored in this cycle, which prevents re-issuing a still-high req.
  - Go to IDLE.
- Timing:
  - Request seen in IDLE at edge t: mem_req is high from t+1.
  - mem_ack sampled at edge k: x_ack is high in cycle k+1.
  - Earliest next mem_req: k+3.
  - With a memory that acks on the first cycle, a transaction takes 3 cycles.
- Boundary conditions:
  - Simultaneous i_req and d_req in IDLE: D wins. I stays pending and is granted on the next IDLE.
  - Requester drops req while BUSY: the transaction still completes and the ack still pulses.
  - mem_ack in IDLE or RESP: ignored, no state change.
  - mem_ack with no outstanding request: ignored.
  - i_ack and d_ack are never high together.
  - mem_req is never high in IDLE or RESP.
  - Addresses pass through unchecked; no alignment check.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on grant and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYC without mem_ack: mem_req = 0, go to RESP, x_ack = 1 with err = 1.
  - On a timed-out read, x_rdata = 0.
- Undefined: no counter; BUSY waits indefinitely; err is constant 0.

Test Plan:
- Reset: rst_ = 0 for 2 cycles with i_req = 1 → all outputs 0 and mem_req = 0. After release, mem_req = 1 on the next edge with mem_addr = i_addr.
- Fetch: i_addr = 0x100, memory acks after 2 cycles with mem_rdata = 0x00500093 → i_ack one cycle with i_rdata = 0x00500093. mem_size = 2, mem_we = 0.
- Contention: i_req and d_req rise together, d_we = 1, d_addr = 0x200, d_wdata = 0xDEADBEEF, d_size = 0 → store issued first with mem_we = 1 and mem_size = 0; d_ack; then fetch issued after RESP; i_ack; no overlap.
- Held req: i_req stays high through i_ack → exactly one mem_req per acknowledged transaction; no duplicate grant in the RESP cycle.
- Stray ack plus mid-op reset: mem_ack pulse in IDLE → no ack. Then rst_ = 0 during BUSY_D → outputs 0 next edge and no d_ack, even if mem_ack follows.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC = 4, memory never acks a load → d_ack with err = 1 and d_rdata = 0 after 4 BUSY cycles; mem_req = 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the core's instruction fetch
//   requester (I) and load/store requester (D). One transaction is in
//   flight at a time; D has fixed priority over I. The memory request is
//   held until mem_ack, then read data and a one-cycle ack go back to the
//   owning requester. All outputs are registered.
//
// Ports
//   clk, rst_        clock (rising edge), synchronous active-low reset
//   i_req/i_addr     fetch request (held until i_ack) and address
//   i_rdata/i_ack    fetched word (held until next I completion), done pulse
//   d_req/d_we/...   load/store request, store flag, address, data, size
//   d_rdata/d_ack    load data (held until next D completion), done pulse
//   mem_*            request/attributes towards memory; mem_rdata/mem_ack back
//   err              timeout pulse aligned with the ack
//
// Optional feature
//   MEM_ARB_TIMEOUT_EN: abandon a transaction after TIMEOUT_CYC busy cycles
//   without mem_ack, ack it with err = 1 (read data forced to 0). Without
//   the macro the arbiter waits indefinitely and err is tied 0.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [1:0]    d_size,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_size,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  // state  | meaning
  // IDLE   | nothing in flight; arbitrate D over I
  // BUSY_I | fetch issued, waiting for mem_ack
  // BUSY_D | load/store issued, waiting for mem_ack
  // RESP   | ack pulse cycle; requests ignored so a held req is not re-issued
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t        r_state, w_state_nxt;
  logic          r_mem_req, w_mem_req_nxt;
  logic          r_mem_we, w_mem_we_nxt;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [1:0]    r_mem_size, w_mem_size_nxt;
  logic [DW-1:0] r_i_rdata, w_i_rdata_nxt;
  logic [DW-1:0] r_d_rdata, w_d_rdata_nxt;
  logic          r_i_ack, w_i_ack_nxt;
  logic          r_d_ack, w_d_ack_nxt;
  logic          w_busy;
  logic          w_timeout;

  assign w_busy = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          r_err, w_err_nxt;

  assign w_cnt_inc = r_cnt + 1'b1;
  // Fires on the busy edge that would bring the count to TIMEOUT_CYC.
  assign w_timeout = w_busy && (w_cnt_inc == CW'(TIMEOUT_CYC));

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_err_nxt = 1'b0;
    // Cleared every idle cycle, so it is zero on the grant edge.
    if (r_state == S_IDLE) begin
      w_cnt_nxt = '0;
    end else if (w_busy) begin
      w_cnt_nxt = w_cnt_inc;
      w_err_nxt = w_timeout && !mem_ack;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign err = r_err;
`else
  logic w_unused_tmo;

  assign w_unused_tmo = |TIMEOUT_CYC;
  assign w_timeout    = 1'b0;
  assign err          = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_size_nxt  = r_mem_size;
    w_i_rdata_nxt   = r_i_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_i_ack_nxt     = 1'b0;
    w_d_ack_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (d_req) begin
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = d_we;
          w_mem_addr_nxt  = d_addr;
          w_mem_wdata_nxt = d_wdata;
          w_mem_size_nxt  = d_size;
          w_state_nxt     = S_BUSY_D;
        end else if (i_req) begin
          // Fetches leave mem_wdata untouched.
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = i_addr;
          w_mem_size_nxt  = SIZE_WORD;
          w_state_nxt     = S_BUSY_I;
        end
      end

      S_BUSY_I: begin
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_i_rdata_nxt = mem_rdata;
          w_i_ack_nxt   = 1'b1;
          w_state_nxt   = S_RESP;
        end else if (w_timeout) begin
          w_mem_req_nxt = 1'b0;
          w_i_rdata_nxt = '0;
          w_i_ack_nxt   = 1'b1;
          w_state_nxt   = S_RESP;
        end
      end

      S_BUSY_D: begin
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          if (!r_mem_we) begin
            w_d_rdata_nxt = mem_rdata;
          end
          w_d_ack_nxt   = 1'b1;
          w_state_nxt   = S_RESP;
        end else if (w_timeout) begin
          w_mem_req_nxt = 1'b0;
          if (!r_mem_we) begin
            w_d_rdata_nxt = '0;
          end
          w_d_ack_nxt   = 1'b1;
          w_state_nxt   = S_RESP;
        end
      end

      S_RESP: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_size  <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_size  <= w_mem_size_nxt;
      r_i_rdata   <= w_i_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_i_ack     <= w_i_ack_nxt;
      r_d_ack     <= w_d_ack_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_size  = r_mem_size;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_ack     = r_i_ack;
  assign d_ack     = r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_(rst_),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_size = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_ = 0; i_req = 1; i_addr = 32'h40;
    tick(); tick();
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_size, i_rdata, i_ack, d_rdata, d_ack, err} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h size=%h ir=%h ia=%b dr=%h da=%b err=%b, required all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_size, i_rdata, i_ack, d_rdata, d_ack, err);
    end
    rst_ = 1;
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      n_errors++;
      $display("FAIL reset_release_grant: got req=%b addr=%h, required 1 / 00000040", mem_req, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h11;
    tick();
    mem_ack = 0; i_req = 0;
    tick();
  endtask

  task automatic test_fetch();
    drive_idle();
    i_req = 1; i_addr = 32'h100;
    tick();
    n_checks++;
    if (mem_req !== 1 || mem_we !== 0 || mem_size !== 2'd2 || mem_addr !== 32'h100) begin
      n_errors++;
      $display("FAIL fetch_issue: got req=%b we=%b size=%0d addr=%h, required 1/0/2/00000100", mem_req, mem_we, mem_size, mem_addr);
    end
    tick();
    n_checks++;
    if (mem_req !== 1 || i_ack !== 0) begin
      n_errors++;
      $display("FAIL fetch_wait: got req=%b i_ack=%b, required 1/0", mem_req, i_ack);
    end
    mem_ack = 1; mem_rdata = 32'h00500093;
    tick();
    n_checks++;
    if (i_ack !== 1 || i_rdata !== 32'h00500093 || mem_req !== 0 || d_ack !== 0) begin
      n_errors++;
      $display("FAIL fetch_ack: got i_ack=%b i_rdata=%h mem_req=%b d_ack=%b, required 1/00500093/0/0", i_ack, i_rdata, mem_req, d_ack);
    end
    mem_ack = 0; i_req = 0;
    tick();
    n_checks++;
    if (i_ack !== 0 || i_rdata !== 32'h00500093) begin
      n_errors++;
      $display("FAIL fetch_ack_pulse: got i_ack=%b i_rdata=%h, required 0/00500093", i_ack, i_rdata);
    end
  endtask

  task automatic test_contention();
    drive_idle();
    i_req = 1; i_addr = 32'h300;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_size = 2'd0;
    tick();
    n_checks++;
    if (mem_req !== 1 || mem_we !== 1 || mem_size !== 0 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL contention_d_first: got req=%b we=%b size=%0d addr=%h wdata=%h, required 1/1/0/00000200/deadbeef",
               mem_req, mem_we, mem_size, mem_addr, mem_wdata);
    end
    mem_ack = 1; mem_rdata = 32'h12345678;
    tick();
    n_checks++;
    if (d_ack !== 1 || i_ack !== 0 || d_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL contention_store_ack: got d_ack=%b i_ack=%b d_rdata=%h, required 1/0/00000000", d_ack, i_ack, d_rdata);
    end
    mem_ack = 0; d_req = 0;
    tick();
    n_checks++;
    if (mem_req !== 0 || d_ack !== 0 || i_ack !== 0) begin
      n_errors++;
      $display("FAIL contention_resp: got mem_req=%b d_ack=%b i_ack=%b, required 0/0/0", mem_req, d_ack, i_ack);
    end
    tick();
    n_checks++;
    if (mem_req !== 1 || mem_we !== 0 || mem_size !== 2 || mem_addr !== 32'h300 || mem_wdata !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL contention_i_second: got req=%b we=%b size=%0d addr=%h wdata=%h, required 1/0/2/00000300/deadbeef",
               mem_req, mem_we, mem_size, mem_addr, mem_wdata);
    end
    mem_ack = 1; mem_rdata = 32'hCAFE0001;
    tick();
    n_checks++;
    if (i_ack !== 1 || d_ack !== 0 || i_rdata !== 32'hCAFE0001) begin
      n_errors++;
      $display("FAIL contention_fetch_ack: got i_ack=%b d_ack=%b i_rdata=%h, required 1/0/cafe0001", i_ack, d_ack, i_rdata);
    end
    mem_ack = 0; i_req = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    int  n_grant = 0;
    int  n_ack = 0;
    bit  prev_req = 0;
    bit  prev_ack = 0;
    drive_idle();
    i_req = 1; i_addr = 32'h400; mem_rdata = 32'h0BADF00D;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (mem_req && !prev_req) n_grant++;
      if (i_ack) n_ack++;
      if (prev_ack) begin
        n_checks++;
        if (mem_req !== 0) begin
          n_errors++;
          $display("FAIL held_req_resp_regrant: cycle %0d got mem_req=%b, required 0", c, mem_req);
        end
      end
      prev_req = mem_req;
      prev_ack = i_ack;
      mem_ack  = mem_req;
    end
    n_checks++;
    if (n_grant != 4 || n_ack != 4) begin
      n_errors++;
      $display("FAIL held_req_counts: got grants=%0d acks=%0d, required 4/4", n_grant, n_ack);
    end
    i_req = 0; mem_ack = 0;
    tick(); tick();
  endtask

  task automatic test_stray_ack_reset();
    drive_idle();
    mem_ack = 1; mem_rdata = 32'h77777777;
    tick();
    n_checks++;
    if (i_ack !== 0 || d_ack !== 0 || mem_req !== 0) begin
      n_errors++;
      $display("FAIL stray_ack_idle: got i_ack=%b d_ack=%b mem_req=%b, required 0/0/0", i_ack, d_ack, mem_req);
    end
    mem_ack = 0;
    d_req = 1; d_we = 0; d_addr = 32'h80; d_size = 2'd2;
    tick();
    n_checks++;
    if (mem_req !== 1 || mem_addr !== 32'h80) begin
      n_errors++;
      $display("FAIL midop_issue: got mem_req=%b addr=%h, required 1/00000080", mem_req, mem_addr);
    end
    rst_ = 0; d_req = 0;
    tick();
    n_checks++;
    if ({mem_req, mem_addr, mem_size, d_ack, i_ack, d_rdata, i_rdata} !== '0) begin
      n_errors++;
      $display("FAIL midop_reset: got mem_req=%b addr=%h size=%0d d_ack=%b d_rdata=%h, required all 0",
               mem_req, mem_addr, mem_size, d_ack, d_rdata);
    end
    rst_ = 1; mem_ack = 1; mem_rdata = 32'hAAAA5555;
    tick();
    n_checks++;
    if (d_ack !== 0 || d_rdata !== 0 || mem_req !== 0) begin
      n_errors++;
      $display("FAIL late_ack_after_reset: got d_ack=%b d_rdata=%h mem_req=%b, required 0/0/0", d_ack, d_rdata, mem_req);
    end
    mem_ack = 0;
    tick();
  endtask

  // Reference model: one transaction at a time, D preferred, 1-cycle ack,
  // one idle-forced response cycle after every completion.
  task automatic test_random();
    int          phase;          // 0 free, 1 transaction open, 2 response cycle
    bit          own_d, is_store;
    logic        e_req, e_we, e_iack, e_dack;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
    logic [1:0]  e_size;
    bit          ri_wait, ri_drop, rd_wait, rd_drop, m_active;
    int          lat;
    drive_idle();
    rst_ = 0;
    tick();
    rst_ = 1;
    phase = 0; own_d = 0; is_store = 0;
    e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_size = 0; e_irdata = 0; e_drdata = 0;
    ri_wait = 0; ri_drop = 0; rd_wait = 0; rd_drop = 0; m_active = 0; lat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      e_iack = 0; e_dack = 0;
      if (phase == 0) begin
        if (d_req) begin
          phase = 1; own_d = 1; is_store = d_we;
          e_req = 1; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_size = d_size;
        end else if (i_req) begin
          phase = 1; own_d = 0; is_store = 0;
          e_req = 1; e_we = 0; e_addr = i_addr; e_size = 2'b10;
        end
      end else if (phase == 1) begin
        if (mem_ack) begin
          phase = 2; e_req = 0;
          if (own_d) begin
            e_dack = 1;
            if (!is_store) e_drdata = mem_rdata;
          end else begin
            e_iack = 1;
            e_irdata = mem_rdata;
          end
        end
      end else begin
        phase = 0;
      end

      n_checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_size} !== {e_req, e_we, e_addr, e_wdata, e_size}) begin
        n_errors++;
        $display("FAIL rand_mem_if cyc %0d: got req=%b we=%b addr=%h wdata=%h size=%0d, required req=%b we=%b addr=%h wdata=%h size=%0d",
                 cyc, mem_req, mem_we, mem_addr, mem_wdata, mem_size, e_req, e_we, e_addr, e_wdata, e_size);
      end
      n_checks++;
      if ({i_ack, d_ack, err} !== {e_iack, e_dack, 1'b0}) begin
        n_errors++;
        $display("FAIL rand_ack cyc %0d: got i_ack=%b d_ack=%b err=%b, required %b/%b/0", cyc, i_ack, d_ack, err, e_iack, e_dack);
      end
      n_checks++;
      if (i_rdata !== e_irdata || d_rdata !== e_drdata) begin
        n_errors++;
        $display("FAIL rand_rdata cyc %0d: got i_rdata=%h d_rdata=%h, required %h/%h", cyc, i_rdata, d_rdata, e_irdata, e_drdata);
      end

      if (ri_wait && i_ack) ri_wait = 0;
      if (rd_wait && d_ack) rd_wait = 0;
      if (!ri_wait && $urandom_range(2) == 0) begin
        ri_wait = 1; ri_drop = 0; i_addr = $urandom;
      end
      if (!rd_wait && $urandom_range(3) == 0) begin
        rd_wait = 1; rd_drop = 0;
        d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom; d_size = 2'($urandom_range(3));
      end
      if (phase == 1 && !own_d && ri_wait && $urandom_range(9) == 0) ri_drop = 1;
      if (phase == 1 && own_d && rd_wait && $urandom_range(9) == 0) rd_drop = 1;
      i_req = ri_wait && !ri_drop;
      d_req = rd_wait && !rd_drop;

      mem_rdata = $urandom;
      if (mem_req) begin
        if (!m_active) begin
          m_active = 1; lat = $urandom_range(3);
        end
        if (lat == 0) begin
          mem_ack = 1; m_active = 0;
        end else begin
          lat--; mem_ack = 0;
        end
      end else begin
        m_active = 0;
        mem_ack = ($urandom_range(7) == 0);
      end
    end
    drive_idle();
    tick(); tick(); tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    drive_idle();
    rst_ = 0;
    tick();
    rst_ = 1;
    d_req = 1; d_we = 0; d_addr = 32'h44; d_size = 2'd2;
    tick();
    mem_ack = 1; mem_rdata = 32'h5A5A5A5A;
    tick();
    n_checks++;
    if (d_ack !== 1 || d_rdata !== 32'h5A5A5A5A || err !== 0) begin
      n_errors++;
      $display("FAIL timeout_preload: got d_ack=%b d_rdata=%h err=%b, required 1/5a5a5a5a/0", d_ack, d_rdata, err);
    end
    mem_ack = 0; d_req = 0;
    tick();
    d_req = 1;
    tick();
    for (int b = 1; b <= 3; b++) begin
      tick();
      n_checks++;
      if (mem_req !== 1 || d_ack !== 0 || err !== 0) begin
        n_errors++;
        $display("FAIL timeout_wait busy %0d: got mem_req=%b d_ack=%b err=%b, required 1/0/0", b, mem_req, d_ack, err);
      end
    end
    tick();
    n_checks++;
    if (d_ack !== 1 || err !== 1 || d_rdata !== 0 || mem_req !== 0) begin
      n_errors++;
      $display("FAIL timeout_fire: got d_ack=%b err=%b d_rdata=%h mem_req=%b, required 1/1/0/0", d_ack, err, d_rdata, mem_req);
    end
    d_req = 0;
    tick();
    n_checks++;
    if (d_ack !== 0 || err !== 0) begin
      n_errors++;
      $display("FAIL timeout_pulse: got d_ack=%b err=%b, required 0/0", d_ack, err);
    end
  endtask
`endif

  initial begin
    rst_ = 0;
    drive_idle();
    test_reset();
    test_fetch();
    test_contention();
    test_back_to_back();
    test_stray_ack_reset();
    test_random();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
